// File: rtl/shift_engine.sv
// shift_engine: bit-counted serial shift unit for the I2C byte path.
// Latency: out/count/busy/done update on the rising clock edge; sout is combinational from out.
// Backpressure: none; the bit FSM paces the unit with one shift strobe per bit,
//   and strobes arriving while idle are ignored.
//
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   load            load ins, clear count, begin a transfer
//   start           begin a transfer keeping current contents (receive-only frames)
//   abort           cancel the active transfer, contents held
//   shift, inb      bit strobe and serial input captured on that strobe
//   ins             parallel load data
//   out, sout       parallel contents and outgoing serial bit
//   count           bits shifted so far in the current transfer
//   busy, done      transfer in progress; one-cycle completion pulse
module shift_engine #(
  parameter int REGISTER_SIZE = 8,
  parameter bit MSB_FIRST     = 1'b1,
  parameter int CW            = $clog2(REGISTER_SIZE + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     shift,
  input  logic                     inb,
  input  logic [REGISTER_SIZE-1:0] ins,
  output logic [REGISTER_SIZE-1:0] out,
  output logic                     sout,
  output logic [CW-1:0]            count,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Count value at which the next accepted shift closes the frame.
  localparam logic [CW-1:0] LAST = CW'(REGISTER_SIZE - 1);

  state_t                   state, state_nxt;
  logic [REGISTER_SIZE-1:0] out_nxt;
  logic [CW-1:0]            count_nxt;
  logic                     done_nxt;
  logic [REGISTER_SIZE-1:0] shifted;

  // Shift direction and outgoing bit are fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {out[REGISTER_SIZE-2:0], inb};
      assign sout    = out[REGISTER_SIZE-1];
    end else begin : g_lsb
      assign shifted = {inb, out[REGISTER_SIZE-1:1]};
      assign sout    = out[0];
    end
  endgenerate

  assign busy = (state == ACTIVE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      out   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

  // abort > load > start > shift. A load/start coinciding with the completing
  // shift takes priority, so the frame restarts and no done pulse is produced.
  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    count_nxt = count;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (load) begin
      out_nxt   = ins;
      count_nxt = '0;
      state_nxt = ACTIVE;
    end else if (start) begin
      count_nxt = '0;
      state_nxt = ACTIVE;
    end else if (shift && (state == ACTIVE)) begin
      out_nxt = shifted;
      if (count == LAST) begin
        count_nxt = '0;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        count_nxt = count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: exercises four shift_engine variants (8/MSB, 8/LSB, 2/MSB, 9/MSB)
// sharing one stimulus stream, each compared every cycle against a frame-level model.
// Directed scenarios plus a randomized phase; prints a single summary line.
module tb_shift_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load, start, abort, shift, inb;
  logic [31:0] ins;

  always #5 clock = ~clock;

  logic [7:0] out_a, out_b;
  logic [1:0] out_c;
  logic [8:0] out_d;
  logic [3:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;
  logic sout_a, sout_b, sout_c, sout_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic done_a, done_b, done_c, done_d;

  shift_engine #(.REGISTER_SIZE(8), .MSB_FIRST(1'b1)) u_a (
    .clock(clock), .reset_n(reset_n), .load(load), .start(start), .abort(abort),
    .shift(shift), .inb(inb), .ins(ins[7:0]), .out(out_a), .sout(sout_a),
    .count(cnt_a), .busy(busy_a), .done(done_a));
  shift_engine #(.REGISTER_SIZE(8), .MSB_FIRST(1'b0)) u_b (
    .clock(clock), .reset_n(reset_n), .load(load), .start(start), .abort(abort),
    .shift(shift), .inb(inb), .ins(ins[7:0]), .out(out_b), .sout(sout_b),
    .count(cnt_b), .busy(busy_b), .done(done_b));
  shift_engine #(.REGISTER_SIZE(2), .MSB_FIRST(1'b1)) u_c (
    .clock(clock), .reset_n(reset_n), .load(load), .start(start), .abort(abort),
    .shift(shift), .inb(inb), .ins(ins[1:0]), .out(out_c), .sout(sout_c),
    .count(cnt_c), .busy(busy_c), .done(done_c));
  shift_engine #(.REGISTER_SIZE(9), .MSB_FIRST(1'b1)) u_d (
    .clock(clock), .reset_n(reset_n), .load(load), .start(start), .abort(abort),
    .shift(shift), .inb(inb), .ins(ins[8:0]), .out(out_d), .sout(sout_d),
    .count(cnt_d), .busy(busy_d), .done(done_d));

  // DUT outputs gathered per variant index.
  logic [31:0] d_out [4];
  logic [31:0] d_cnt [4];
  logic        d_sout[4], d_busy[4], d_done[4];
  assign d_out[0] = 32'(out_a);  assign d_cnt[0] = 32'(cnt_a);
  assign d_out[1] = 32'(out_b);  assign d_cnt[1] = 32'(cnt_b);
  assign d_out[2] = 32'(out_c);  assign d_cnt[2] = 32'(cnt_c);
  assign d_out[3] = 32'(out_d);  assign d_cnt[3] = 32'(cnt_d);
  assign d_sout[0] = sout_a; assign d_sout[1] = sout_b; assign d_sout[2] = sout_c; assign d_sout[3] = sout_d;
  assign d_busy[0] = busy_a; assign d_busy[1] = busy_b; assign d_busy[2] = busy_c; assign d_busy[3] = busy_d;
  assign d_done[0] = done_a; assign d_done[1] = done_b; assign d_done[2] = done_c; assign d_done[3] = done_d;

  // Reference model: frame contents as an integer, number of bits moved so far,
  // and whether a frame is open.
  int          mw [4] = '{8, 8, 2, 9};
  bit          mmsb[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] m_out[4];
  int          m_cnt[4];
  bit          m_busy[4], m_done[4];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_out[i] = '0; m_cnt[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      m_done[i] = 1'b0;
      if (abort) begin
        m_busy[i] = 1'b0; m_cnt[i] = 0;
      end else if (load) begin
        m_out[i] = ins & wmask(mw[i]); m_cnt[i] = 0; m_busy[i] = 1'b1;
      end else if (start) begin
        m_cnt[i] = 0; m_busy[i] = 1'b1;
      end else if (shift && m_busy[i]) begin
        if (mmsb[i]) m_out[i] = ((m_out[i] << 1) | 32'(inb)) & wmask(mw[i]);
        else         m_out[i] = (m_out[i] >> 1) | (32'(inb) << (mw[i] - 1));
        m_cnt[i]++;
        if (m_cnt[i] == mw[i]) begin
          m_cnt[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] mo;
    for (int i = 0; i < 4; i++) begin
      mo = m_out[i];
      check($sformatf("%s.v%0d.out", tag, i), d_out[i], mo);
      check($sformatf("%s.v%0d.count", tag, i), d_cnt[i], 32'(m_cnt[i]));
      check($sformatf("%s.v%0d.busy", tag, i), 32'(d_busy[i]), 32'(m_busy[i]));
      check($sformatf("%s.v%0d.done", tag, i), 32'(d_done[i]), 32'(m_done[i]));
      check($sformatf("%s.v%0d.sout", tag, i), 32'(d_sout[i]),
            32'(mmsb[i] ? mo[mw[i]-1] : mo[0]));
    end
  endtask

  // Drive inputs at the falling edge, let the model follow the rising edge,
  // compare 1 time unit later, then return at the next falling edge.
  task automatic step(input bit l, input bit st, input bit ab, input bit sh,
                      input bit ib, input logic [31:0] iv);
    load = l; start = st; abort = ab; shift = sh; inb = ib; ins = iv;
    @(posedge clock);
    model_edge();
    #1;
    check_all("cyc");
    @(negedge clock);
  endtask

  logic [7:0] pa, pb, pc;
  int first_c, first_d;

  initial begin
    pa = 8'hA5; pb = 8'h3C; pc = 8'hC3;
    reset_n = 1'b0; load = 0; start = 0; abort = 0; shift = 0; inb = 0; ins = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;

    // MSB-first transmit A5 while receiving 3C.
    step(1, 0, 0, 0, 0, 32'hA5);
    for (int k = 0; k < 8; k++) begin
      check("msb_sout", 32'(sout_a), 32'(pa[7-k]));
      check("msb_count", 32'(cnt_a), 32'(k));
      step(0, 0, 0, 1, pb[7-k], 32'h0);
      check("msb_done", 32'(done_a), 32'(k == 7));
    end
    check("msb_out", 32'(out_a), 32'h3C);
    check("msb_busy", 32'(busy_a), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    check("msb_done_pulse", 32'(done_a), 32'h0);

    // LSB-first transmit A5 with inb held high.
    step(1, 0, 0, 0, 0, 32'hA5);
    for (int k = 0; k < 8; k++) begin
      check("lsb_sout", 32'(sout_b), 32'(pa[k]));
      step(0, 0, 0, 1, 1'b1, 32'h0);
      check("lsb_done", 32'(done_b), 32'(k == 7));
    end
    check("lsb_out", 32'(out_b), 32'hFF);

    // Shifts separated by idle gaps.
    step(1, 0, 0, 0, 0, 32'hA5);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1, pb[k], 32'h0);
      check("gap_done", 32'(done_a), 32'(k == 7));
      repeat (3) step(0, 0, 0, 0, 1'b1, 32'h0);
    end

    // Shifts while idle are ignored.
    repeat (4) begin
      step(0, 0, 0, 1, 1'b1, 32'h0);
      check("idle_out", 32'(out_a), 32'h3C);
      check("idle_done", 32'(done_a), 32'h0);
    end

    // Abort after three shifts.
    step(1, 0, 0, 0, 0, 32'hA5);
    repeat (3) step(0, 0, 0, 1, 1'b1, 32'h0);
    step(0, 0, 1, 1, 1'b1, 32'h0);
    check("abort_busy", 32'(busy_a), 32'h0);
    check("abort_count", 32'(cnt_a), 32'h0);
    check("abort_out", 32'(out_a), 32'h2F);
    check("abort_done", 32'(done_a), 32'h0);

    // Load on the completing shift restarts without done.
    step(1, 0, 0, 0, 0, 32'hA5);
    repeat (7) step(0, 0, 0, 1, 1'b0, 32'h0);
    step(1, 0, 0, 1, 1'b0, 32'h5A);
    check("reload_done", 32'(done_a), 32'h0);
    check("reload_busy", 32'(busy_a), 32'h1);
    check("reload_count", 32'(cnt_a), 32'h0);
    check("reload_out", 32'(out_a), 32'h5A);

    // Receive-only frame started with start on cleared contents.
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, pc[7-k], 32'h0);
    check("rx_out", 32'(out_a), 32'hC3);
    check("rx_done", 32'(done_a), 32'h1);

    // Frame length for the narrow and odd-width variants.
    first_c = -1; first_d = -1;
    step(1, 0, 0, 0, 0, $urandom);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 1, 1'($urandom), 32'h0);
      if (done_c && first_c < 0) first_c = k;
      if (done_d && first_d < 0) first_d = k;
    end
    check("w2_done_at", 32'(first_c), 32'd2);
    check("w9_done_at", 32'(first_d), 32'd9);

    // Asynchronous reset in mid-cycle, mid-transfer.
    step(1, 0, 0, 0, 0, 32'h1FF);
    step(0, 0, 0, 1, 1'b1, 32'h0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #1 reset_n = 1'b1;
    @(negedge clock);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 47) == 0, $urandom_range(0, 2) != 0,
           1'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
Parametrised shift engine for the I2C byte path. It replaces the plain load/shift register with a bit-counted transfer unit. The unit shifts out one frame of serial data while capturing serial input. It supports MSB-first or LSB-first order, counts bits itself, and reports completion with busy and done. The I2C bit-level FSM drives it: it issues one shift strobe per SCL bit and reacts to done to run the ACK phase.

Parameters:
REGISTER_SIZE, 8, frame width in bits; legal values 2..32
MSB_FIRST, 1, 1 = shift toward MSB (serial out = out[REGISTER_SIZE-1], serial in enters bit 0); 0 = shift toward LSB (serial out = out[0], serial in enters bit REGISTER_SIZE-1)
CW, $clog2(REGISTER_SIZE+1), width of the bit counter; derived, never overridden

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
load  input  1  load ins, clear counter, start a transfer
start  input  1  start a transfer keeping current contents (receive-only frames)
abort  input  1  cancel the active transfer; contents held
shift  input  1  one bit-time strobe: present next bit, capture inb
inb  input  1  serial data in
ins  input  REGISTER_SIZE  parallel load data
out  output  REGISTER_SIZE  parallel register contents
sout  output  1  serial data out (combinational from out)
count  output  CW  bits shifted in current transfer
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when transfer completes

Behaviour:
- Reset (async, reset_n=0): out=0, count=0, busy=0, done=0. sout follows out, so sout=0.
- States: IDLE (busy=0) and ACTIVE (busy=1). Register, counter and state update on rising clock only.
- Priority each cycle is abort > load > start > shift.
- abort: state goes to IDLE and count=0. out is held. done is not asserted.
- load, any state: out=ins, count=0, state goes to ACTIVE.
- start, any state: count=0, state goes to ACTIVE. out is held.
- shift in ACTIVE:
  - MSB_FIRST=1: out={out[REGISTER_SIZE-2:0], inb}.
  - MSB_FIRST=0: out={inb, out[REGISTER_SIZE-1:1]}.
  - count increments by 1.
- shift in IDLE: ignored. out and count are held and done stays 0.
- Completion: a shift in ACTIVE with count==REGISTER_SIZE-1 completes the frame.
  - Same edge: count returns to 0, state goes to IDLE, done=1.
  - done returns to 0 on the next edge.
  - Completion latency is exactly REGISTER_SIZE accepted shifts after load/start.
- Restart: load or start on the same edge as a completing shift wins. done is not asserted, count=0, and the state stays ACTIVE.
- sout is the bit on the outgoing end of the current out:
  - It is valid from the edge after load, before the first shift.
  - After shift k it presents frame bit k+1.
- No shift in a cycle: out and count hold.
- Throughput: back-to-back shifts on consecutive cycles are legal.
- count never exceeds REGISTER_SIZE-1 while observable. It wraps only through the completion rule.
- Reset mid-transfer: async clear as above. No done pulse.

Test Plan:
- Reset then idle: assert reset_n=0 mid-cycle -> out=0, count=0, busy=0, done=0 immediately, without waiting for a clock edge.
- MSB-first TX/RX (REGISTER_SIZE=8, MSB_FIRST=1):
  - Stimulus: load ins=8'hA5, then 8 consecutive shifts with inb driving 8'h3C MSB first.
  - Required: sout sequence 1,0,1,0,0,1,0,1 and count 0..7.
  - On the 8th shift edge: out=8'h3C, busy=0, done=1 for exactly one cycle.
- LSB-first (MSB_FIRST=0):
  - Stimulus: load 8'hA5, 8 shifts with inb=1.
  - Required: sout sequence 1,0,1,0,0,1,0,1 (LSB first), final out=8'hFF, done pulse on the 8th shift.
- Gaps and idle shifts:
  - Shifts separated by 3 idle cycles: out and count hold between shifts, and done comes only on the 8th shift.
  - Shifts issued while busy=0: out unchanged, no done.
- Abort and restart:
  - Abort after 3 shifts: busy=0, count=0, out holds the partially shifted value, no done.
  - load 8'h5A on the same edge as the 8th shift: no done, busy=1, count=0, out=8'h5A.
- Receive-only with start and width variants:
  - start with out=8'h00, 8 shifts of inb pattern 8'hC3: out=8'hC3, done pulse.
  - Repeat the suite at REGISTER_SIZE=2 and REGISTER_SIZE=9 (CW=4): done after exactly 2 and 9 shifts.
